// File: rtl/axi_stream_buffer_pkg.sv
// Shared definitions for the AXI-stream elastic buffer.
//   T_DATA_BIT_DEF / T_USER_WIDTH_DEF : default bus widths
//   entry_def_t                       : stored entry layout {user, data} at default widths
//   clog2_depth()                     : ceil(log2(n)) for pointer and level widths
package axi_stream_pkg;

  localparam int unsigned T_DATA_BIT_DEF   = 128;
  localparam int unsigned T_USER_WIDTH_DEF = 16;

  // User sideband sits above data so both travel as one stored word.
  typedef struct packed {
    logic [T_USER_WIDTH_DEF-1:0] user;
    logic [T_DATA_BIT_DEF-1:0]   data;
  } entry_def_t;

  function automatic int unsigned clog2_depth(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_stream_buffer_if.sv
// Producer (t_*) and consumer (rx_*) stream channels of the elastic buffer.
//   master : test/system side - drives t_valid/t_data/t_user and rx_ready
//   slave  : buffer side      - drives t_ready and rx_valid/rx_data/rx_user
interface axi_stream_buffer_if #(
  parameter int unsigned T_DATA_BIT   = 128,
  parameter int unsigned T_USER_WIDTH = 16
);
  logic                    t_valid;
  logic                    t_ready;
  logic [T_DATA_BIT-1:0]   t_data;
  logic [T_USER_WIDTH-1:0] t_user;
  logic                    rx_valid;
  logic                    rx_ready;
  logic [T_DATA_BIT-1:0]   rx_data;
  logic [T_USER_WIDTH-1:0] rx_user;

  modport master (
    output t_valid, t_data, t_user, rx_ready,
    input  t_ready, rx_valid, rx_data, rx_user
  );

  modport slave (
    input  t_valid, t_data, t_user, rx_ready,
    output t_ready, rx_valid, rx_data, rx_user
  );
endinterface

// File: rtl/axi_stream_buffer_mem.sv
// Entry storage: DEPTH x WIDTH register array.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address (asynchronous read)
//   o_rdata : entry at i_raddr
// Contents are never cleared; validity is tracked by the controller.
module axi_stream_buffer_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 144,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi_stream_buffer.sv
// AXI-stream elastic buffer with first-word-fall-through output.
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   flush       : synchronous discard of all stored words
//   bus         : t_* producer channel in, rx_* consumer channel out
//   level       : current occupancy 0..DEPTH
//   almost_full : level >= AF_THRESH
module axi_stream_buffer
  import axi_stream_pkg::*;
#(
  parameter int unsigned T_DATA_BIT   = T_DATA_BIT_DEF,
  parameter int unsigned T_USER_WIDTH = T_USER_WIDTH_DEF,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AF_THRESH    = DEPTH - 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  axi_stream_buffer_if.slave                bus,
  output logic [clog2_depth(DEPTH+1)-1:0]   level,
  output logic                              almost_full
);

  localparam int unsigned PW = clog2_depth(DEPTH);
  localparam int unsigned LW = clog2_depth(DEPTH + 1);
  localparam int unsigned EW = T_DATA_BIT + T_USER_WIDTH;

  typedef struct packed {
    logic [T_USER_WIDTH-1:0] user;
    logic [T_DATA_BIT-1:0]   data;
  } entry_t;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic   w_t_ready;
  logic   w_rx_valid;
  logic   w_push;
  logic   w_pop;
  entry_t w_wr_entry;
  entry_t w_rd_entry;

  // t_ready depends only on registered level, flush and reset: a pop
  // at full frees space for the next cycle, not this one.
  always_comb begin
    w_t_ready  = rst_n & ~flush & (r_level < LW'(DEPTH));
    w_rx_valid = (r_level != '0);
    w_push     = bus.t_valid & w_t_ready;
    w_pop      = w_rx_valid & bus.rx_ready & ~flush;
    w_wr_entry = '{user: bus.t_user, data: bus.t_data};
  end

  axi_stream_buffer_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_entry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Output mux is gated so stale storage never shows when empty.
  always_comb begin
    bus.t_ready  = w_t_ready;
    bus.rx_valid = w_rx_valid;
    bus.rx_data  = w_rx_valid ? w_rd_entry.data : '0;
    bus.rx_user  = w_rx_valid ? w_rd_entry.user : '0;
    level        = r_level;
    almost_full  = (r_level >= LW'(AF_THRESH));
  end

endmodule

// File: tb/tb_axi_stream_buffer.sv
module tb_axi_stream_buffer;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [3:0] level;
  logic       almost_full;

  int n_tests = 0;
  int n_fail  = 0;

  axi_stream_buffer_if #(.T_DATA_BIT(128), .T_USER_WIDTH(16)) bus ();

  axi_stream_buffer #(
    .T_DATA_BIT   (128),
    .T_USER_WIDTH (16),
    .DEPTH        (8),
    .AF_THRESH    (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .level       (level),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] exp_q [$];
  logic [15:0]  expu_q [$];

  initial begin
    int sent, rcvd, cyc;
    bit held;
    logic [127:0] hd;
    logic [15:0]  hu;

    rst_n        = 1'b0;
    flush        = 1'b0;
    bus.t_valid  = 1'b1;
    bus.t_data   = 128'h55;
    bus.t_user   = 16'h1234;
    bus.rx_ready = 1'b0;

    // Reset held for 3 cycles with t_valid=1
    repeat (3) tick();
    #1;
    check("rst_t_ready", bus.t_ready, 1'b0);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_level", level, 4'd0);
    check("rst_af", almost_full, 1'b0);
    check("rst_rx_data", bus.rx_data, 128'h0);
    check("rst_rx_user", bus.rx_user, 16'h0);
    rst_n       = 1'b1;
    bus.t_valid = 1'b0;
    #1;
    check("rel_t_ready", bus.t_ready, 1'b1);
    check("rel_level", level, 4'd0);
    tick();

    // Fill with rx_ready=0
    for (int i = 1; i <= 8; i++) begin
      bus.t_valid = 1'b1;
      bus.t_data  = 128'(i);
      bus.t_user  = 16'hA000 + 16'(i);
      #1;
      check("fill_t_ready", bus.t_ready, 1'b1);
      check("fill_level", level, 4'(i - 1));
      check("fill_af", almost_full, (i - 1) >= 6);
      tick();
    end
    bus.t_data = 128'hDEAD;
    #1;
    check("full_t_ready", bus.t_ready, 1'b0);
    check("full_level", level, 4'd8);
    check("full_af", almost_full, 1'b1);
    tick();
    bus.t_valid = 1'b0;
    #1;
    check("full_hold_level", level, 4'd8);
    check("full_head_data", bus.rx_data, 128'h1);
    check("full_head_user", bus.rx_user, 16'hA001);

    // Drain
    bus.rx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      check("drain_valid", bus.rx_valid, 1'b1);
      check("drain_data", bus.rx_data, 128'(i));
      check("drain_user", bus.rx_user, 16'hA000 + 16'(i));
      tick();
    end
    check("drained_valid", bus.rx_valid, 1'b0);
    check("drained_level", level, 4'd0);
    check("drained_data", bus.rx_data, 128'h0);
    tick();
    check("empty_pop_level", level, 4'd0);

    // Streaming: 100 words, one per cycle
    bus.t_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.t_data = 128'd100 + 128'(i);
      bus.t_user = 16'h3000 + 16'(i);
      #1;
      check("stream_t_ready", bus.t_ready, 1'b1);
      if (i == 0) begin
        check("stream_first_empty", bus.rx_valid, 1'b0);
      end else begin
        check("stream_level", level, 4'd1);
        check("stream_valid", bus.rx_valid, 1'b1);
        check("stream_data", bus.rx_data, 128'd100 + 128'(i - 1));
        check("stream_user", bus.rx_user, 16'h3000 + 16'(i - 1));
      end
      tick();
    end
    bus.t_valid = 1'b0;
    #1;
    check("stream_last", bus.rx_data, 128'd199);
    tick();
    check("stream_end_level", level, 4'd0);
    bus.rx_ready = 1'b0;

    // Full plus simultaneous pop
    for (int i = 0; i < 8; i++) begin
      bus.t_valid = 1'b1;
      bus.t_data  = 128'h10 + 128'(i);
      bus.t_user  = 16'hB000 + 16'(i);
      tick();
    end
    check("fp_level8", level, 4'd8);
    bus.rx_ready = 1'b1;
    bus.t_data   = 128'h99;
    bus.t_user   = 16'hB099;
    #1;
    check("fp_no_push", bus.t_ready, 1'b0);
    tick();
    check("fp_level7", level, 4'd7);
    check("fp_head", bus.rx_data, 128'h11);
    bus.rx_ready = 1'b0;
    #1;
    check("fp_ready_next", bus.t_ready, 1'b1);
    tick();
    bus.t_valid = 1'b0;
    check("fp_level8b", level, 4'd8);
    bus.rx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      check("fp_drain", bus.rx_data, (i < 8) ? 128'h10 + 128'(i) : 128'h99);
      check("fp_drain_user", bus.rx_user, (i < 8) ? 16'hB000 + 16'(i) : 16'hB099);
      tick();
    end
    check("fp_empty", bus.rx_valid, 1'b0);

    // Back-pressure stability with scoreboard, 40 words (wraps pointers)
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    held = 1'b0;
    hd   = '0;
    hu   = '0;
    while (rcvd < 40 && cyc < 1000) begin
      bus.t_valid  = (sent < 40);
      bus.t_data   = {96'hC0FFEE, 32'(sent * 13 + 5)};
      bus.t_user   = 16'h7000 + 16'(sent);
      bus.rx_ready = 1'($urandom_range(0, 1));
      #1;
      if (held) begin
        check("bp_hold_valid", bus.rx_valid, 1'b1);
        check("bp_hold_data", bus.rx_data, hd);
        check("bp_hold_user", bus.rx_user, hu);
      end
      held = 1'b0;
      if (bus.rx_valid && !bus.rx_ready) begin
        held = 1'b1;
        hd   = bus.rx_data;
        hu   = bus.rx_user;
      end
      if (bus.rx_valid && bus.rx_ready) begin
        if (exp_q.size() == 0) begin
          check("bp_spurious", bus.rx_valid, 1'b0);
        end else begin
          check("bp_data", bus.rx_data, exp_q.pop_front());
          check("bp_user", bus.rx_user, expu_q.pop_front());
        end
        rcvd++;
      end
      if (bus.t_valid && bus.t_ready) begin
        exp_q.push_back(bus.t_data);
        expu_q.push_back(bus.t_user);
        sent++;
      end
      tick();
      cyc++;
    end
    check("bp_all_received", 32'(rcvd), 32'd40);
    check("bp_empty", bus.rx_valid, 1'b0);
    bus.t_valid  = 1'b0;
    bus.rx_ready = 1'b0;

    // Flush at level 5
    for (int i = 0; i < 5; i++) begin
      bus.t_valid = 1'b1;
      bus.t_data  = 128'h50 + 128'(i);
      bus.t_user  = 16'hF000 + 16'(i);
      tick();
    end
    check("fl_level5", level, 4'd5);
    flush        = 1'b1;
    bus.t_data   = 128'h77;
    bus.rx_ready = 1'b1;
    #1;
    check("fl_t_ready", bus.t_ready, 1'b0);
    check("fl_rx_valid", bus.rx_valid, 1'b1);
    tick();
    flush        = 1'b0;
    bus.t_valid  = 1'b0;
    bus.rx_ready = 1'b0;
    #1;
    check("fl_level0", level, 4'd0);
    check("fl_valid0", bus.rx_valid, 1'b0);
    check("fl_data0", bus.rx_data, 128'h0);
    bus.t_valid = 1'b1;
    bus.t_data  = 128'h42;
    bus.t_user  = 16'h0042;
    tick();
    bus.t_valid = 1'b0;
    #1;
    check("fl_next_valid", bus.rx_valid, 1'b1);
    check("fl_next_data", bus.rx_data, 128'h42);
    check("fl_next_user", bus.rx_user, 16'h0042);
    check("fl_next_level", level, 4'd1);

    // Reset mid-operation discards contents
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("mr_level", level, 4'd0);
    check("mr_valid", bus.rx_valid, 1'b0);
    check("mr_t_ready", bus.t_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
